// File: rtl/nibble_switch_fifo_if.sv
// rtl/nibble_switch_fifo_if.sv - stream/FIFO bundle for nibble_switch_fifo.
// Optional outDropCnt exists only when NSWITCH_DROP_CNT_EN is defined.
interface nibble_switch_fifo_if #(
  parameter int DATA_W  = 4,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 2,
  parameter int DEPTH   = 8,
  parameter int DST_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic [NUM_IN*DATA_W-1:0]  inData;
  logic [NUM_IN*DST_W-1:0]   inDest;
  logic [NUM_IN-1:0]         inValid;
  logic [NUM_IN-1:0]         outReady;
  logic [NUM_OUT-1:0]        inReadEnable;
  logic [NUM_OUT*DATA_W-1:0] outData;
  logic [NUM_OUT-1:0]        outValid;
  logic [NUM_OUT*LW-1:0]     outLevel;
  logic [NUM_OUT-1:0]        outFull;
  logic [NUM_OUT-1:0]        outEmpty;
  logic                      outError;
`ifdef NSWITCH_DROP_CNT_EN
  logic [NUM_IN*8-1:0]       outDropCnt;

  modport master (
    output inData, inDest, inValid, inReadEnable,
    input  outReady, outData, outValid, outLevel, outFull, outEmpty, outError, outDropCnt
  );
  modport slave (
    input  inData, inDest, inValid, inReadEnable,
    output outReady, outData, outValid, outLevel, outFull, outEmpty, outError, outDropCnt
  );
`else
  modport master (
    output inData, inDest, inValid, inReadEnable,
    input  outReady, outData, outValid, outLevel, outFull, outEmpty, outError
  );
  modport slave (
    input  inData, inDest, inValid, inReadEnable,
    output outReady, outData, outValid, outLevel, outFull, outEmpty, outError
  );
`endif
endinterface

// File: rtl/nibble_switch_fifo.sv
// rtl/nibble_switch_fifo.sv - per-word routed NUM_IN x NUM_OUT switch into round-robin arbitrated output FIFOs.
// Optional per-input refused-cycle counters are built when NSWITCH_DROP_CNT_EN is defined.
module nibble_switch_fifo #(
  parameter int DATA_W  = 4,
  parameter int NUM_IN  = 2,
  parameter int NUM_OUT = 2,
  parameter int DEPTH   = 8,
  parameter int DST_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                  inClock,
  input  logic                  inReset,
  nibble_switch_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [DATA_W-1:0] mem_q    [NUM_OUT][DEPTH];
  logic [AW-1:0]     wr_ptr_q [NUM_OUT];
  logic [AW-1:0]     rd_ptr_q [NUM_OUT];
  logic [LW-1:0]     level_q  [NUM_OUT];
  logic [IW-1:0]     rr_q     [NUM_OUT];
  logic [DATA_W-1:0] dout_q   [NUM_OUT];
  logic [NUM_OUT-1:0] valid_q;
  logic               err_q;

  logic [NUM_OUT-1:0] wr_en;
  logic [NUM_OUT-1:0] pop;
  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] empty;
  logic [IW-1:0]      grant_idx [NUM_OUT];
  logic [DATA_W-1:0]  wr_data   [NUM_OUT];
  logic [NUM_IN-1:0]  ready;
  logic               err_set;

  always_comb begin
    for (int j = 0; j < NUM_OUT; j++) begin
      full[j]  = (level_q[j] == LW'(DEPTH));
      empty[j] = (level_q[j] == '0);
    end
  end

  assign pop = bus.inReadEnable & ~empty;

  // Ready is a function of arbitration and registered fullness only, never of the pop request.
  always_comb begin : arb
    int  idx;
    logic found;
    ready   = '0;
    wr_en   = '0;
    err_set = 1'b0;
    idx     = 0;
    found   = 1'b0;
    for (int j = 0; j < NUM_OUT; j++) begin
      grant_idx[j] = '0;
      wr_data[j]   = '0;
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(bus.inDest[i*DST_W +: DST_W]) >= NUM_OUT) begin
        ready[i] = 1'b1;
        if (bus.inValid[i]) err_set = 1'b1;
      end
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      found = 1'b0;
      for (int k = 1; k <= NUM_IN; k++) begin
        idx = int'(rr_q[j]) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        if (!found && bus.inValid[idx] && int'(bus.inDest[idx*DST_W +: DST_W]) == j) begin
          found        = 1'b1;
          grant_idx[j] = IW'(idx);
        end
      end
      if (found && !full[j]) begin
        wr_en[j]              = 1'b1;
        ready[grant_idx[j]]   = 1'b1;
        wr_data[j]            = bus.inData[int'(grant_idx[j])*DATA_W +: DATA_W];
      end
    end
    if (inReset) ready = '0;
  end

  always_ff @(posedge inClock) begin
    for (int j = 0; j < NUM_OUT; j++) begin
      if (wr_en[j]) mem_q[j][wr_ptr_q[j]] <= wr_data[j];
    end
  end

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        wr_ptr_q[j] <= '0;
        rd_ptr_q[j] <= '0;
        level_q[j]  <= '0;
        rr_q[j]     <= IW'(NUM_IN - 1);
        dout_q[j]   <= '0;
      end
      valid_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (wr_en[j]) begin
          wr_ptr_q[j] <= wr_ptr_q[j] + AW'(1);
          rr_q[j]     <= grant_idx[j];
        end
        if (pop[j]) begin
          rd_ptr_q[j] <= rd_ptr_q[j] + AW'(1);
          dout_q[j]   <= mem_q[j][rd_ptr_q[j]];
        end
        level_q[j] <= level_q[j] + LW'(wr_en[j]) - LW'(pop[j]);
      end
      valid_q <= pop;
      err_q   <= err_q | err_set;
    end
  end

  assign bus.outReady = ready;
  assign bus.outValid = valid_q;
  assign bus.outFull  = full;
  assign bus.outEmpty = empty;
  assign bus.outError = err_q;

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
    assign bus.outData[j*DATA_W +: DATA_W] = dout_q[j];
    assign bus.outLevel[j*LW +: LW]        = level_q[j];
  end

`ifdef NSWITCH_DROP_CNT_EN
  logic [7:0] drop_q [NUM_IN];

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      for (int i = 0; i < NUM_IN; i++) drop_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (bus.inValid[i] && !ready[i] && drop_q[i] != 8'hFF) drop_q[i] <= drop_q[i] + 8'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_drop
    assign bus.outDropCnt[i*8 +: 8] = drop_q[i];
  end
`endif
endmodule

// File: doc/nibble_switch_fifo.md
# nibble_switch_fifo

Parametrised successor to the fixed MUX/DEMUX + FIFO datapath. It routes `NUM_IN` valid/ready input streams to `NUM_OUT` output FIFOs. Each input word carries its own destination select, so routing is per word rather than static. Each output FIFO has a per-output round-robin arbiter and is drained by an independent read enable. It sits between the front-end FIFO stage and the downstream consumers of the Zigbee datapath, replacing the hand-wired select lines.

## Interface
- `DATA_W`, 4: word width in bits.
- `NUM_IN`, 2: number of input channels (≥1).
- `NUM_OUT`, 2: number of output channels/FIFOs (≥1).
- `DEPTH`, 8: words per output FIFO; power of two, ≥2.
- `DST_W`, `$clog2(NUM_OUT)` (min 1): destination select width.

Ports (one clock; reset is asynchronous and active-high):
- `inClock`  in  1  system clock; all state on rising edge.
- `inReset`  in  1  asynchronous, active-high reset.
- `inData`  in  NUM_IN*DATA_W  input words; channel i at bits [i*DATA_W +: DATA_W].
- `inDest`  in  NUM_IN*DST_W  destination output index per input.
- `inValid`  in  NUM_IN  input word valid per channel.
- `outReady`  out  NUM_IN  word accepted this cycle (combinational).
- `inReadEnable`  in  NUM_OUT  pop request per output FIFO.
- `outData`  out  NUM_OUT*DATA_W  registered popped word per output.
- `outValid`  out  NUM_OUT  one-cycle pulse: `outData` slice updated.
- `outLevel`  out  NUM_OUT*($clog2(DEPTH)+1)  occupancy per FIFO.
- `outFull`, `outEmpty`  out  NUM_OUT each  FIFO status flags.
- `outError`  out  1  sticky; set by any accepted word with `inDest ≥ NUM_OUT`.
- `outDropCnt`  out  NUM_IN*8  refused-cycle counters; present only with the macro in Configuration.

## Operation
- **Request.** Input i requests output `d = inDest[i]` when `inValid[i]=1`.
- **Arbitration, per output j.** Grant one requester per cycle, round-robin.
  - Search order starts at `rr_ptr[j]+1` mod `NUM_IN`.
  - `rr_ptr[j]` updates to the granted index only on an accepted write.
- **Acceptance.** `outReady[i] = grant && !outFull[j]`. A word is written on the edge where `inValid[i] && outReady[i]`.
- **Invalid destination** (`d ≥ NUM_OUT`). `outReady[i]=1` and the word is discarded. `outError` is set and stays set until reset. No FIFO is affected.
- **Ready independence.** `outReady` must not depend on `inReadEnable`. A full FIFO refuses writes even if a read occurs the same cycle.
- **Pop.** A pop occurs when `inReadEnable[j] && !outEmpty[j]`. The head word goes to the `outData` slice; `outValid[j]=1` the following cycle. A pop request on an empty FIFO is ignored, with no error. There is no fall-through: a word written this cycle is not readable until the next cycle.
- **Occupancy.** `outLevel` = writes − pops, width `$clog2(DEPTH)+1`. Pointers are `$clog2(DEPTH)` bits and wrap naturally.
- **Simultaneous write and pop** on a non-full, non-empty FIFO: `outLevel` is unchanged and both take effect.

## Timing
- **Reset values.**
  - All FIFOs empty: `outLevel=0`, `outEmpty=1`, `outFull=0`.
  - `outData=0`, `outValid=0`, `outError=0`.
  - `rr_ptr=NUM_IN-1`, so input 0 has first priority.
  - `outDropCnt=0`.
- **Reset mid-operation.** Asynchronous reset discards FIFO contents immediately. `outReady` is 0 while `inReset=1`.
- **Write latency.**
  - `outEmpty` deasserts and `outLevel` increments on the edge of acceptance.
  - Earliest pop is the next cycle; data appears one cycle after that pop.
  - Minimum in-to-out latency is 2 cycles.
- **Throughput.** One write and one pop per output per cycle. Up to `min(NUM_IN,NUM_OUT)` inputs can be accepted concurrently when their destinations differ.
- **Flag timing.** `outFull` and `outEmpty` are registered-state derived: valid from the edge and stable throughout the cycle.

## Configuration
- **`NSWITCH_DROP_CNT_EN`.**
  - When defined, per input i an 8-bit saturating counter increments every cycle where `inValid[i] && !outReady[i]`. It holds at 255 and clears only on reset. It is exported on `outDropCnt`.
  - When undefined, `outDropCnt` is absent from the port list and no counter logic is built.

## Test plan
- **Basic write/read.** Reset, then input 0 writes 0xA to dest 1; pulse `inReadEnable[1]` 1 cycle later.
  - Expect `outData[1]=0xA` and `outValid[1]=1` one cycle after the pop.
  - Expect `outLevel[1]` 1→0.
- **Fill to full.** Write 8 words (0..7) to dest 0 with no reads.
  - Expect `outFull[0]=1` after the 8th write and `outReady` low on the 9th.
  - Popping 8 times yields 0..7 in order, then `outEmpty[0]=1`.
- **Round-robin contention.** Both inputs hold valid to dest 0 for 4 cycles.
  - Grants alternate 0,1,0,1; FIFO order matches the grants.
- **Invalid destination.** `NUM_OUT=3`, send `inDest=3`.
  - Expect `outReady=1`, no level change in any FIFO, and `outError=1` held until reset.
- **Full plus simultaneous pop.** FIFO full, write and pop in the same cycle.
  - The write is refused and the level drops to 7.
  - With the macro defined, `outDropCnt` increments by 1.
- **Reset mid-stream.** Assert `inReset` with 5 words queued.
  - All FIFOs read empty immediately; after release the next write returns the new word, not stale data.
